regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter CNT_W, default 16; width of the write-statistics counter.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 alu_valid  in  1  ALU writeback request.
REQ-005 alu_rd  in  5  ALU destination register index.
REQ-006 alu_data  in  32  ALU writeback value.
REQ-007 alu_ready  out  1  ALU request accepted this cycle (combinational).
REQ-008 mem_valid  in  1  load writeback request.
REQ-009 mem_rd  in  5  load destination register index.
REQ-010 mem_data  in  32  load writeback value.
REQ-011 mem_ready  out  1  load request accepted this cycle (combinational).
REQ-012 rd  out  5  registered write index to register file.
REQ-013 writedata  out  32  registered write data to register file.
REQ-014 regwrite  out  1  registered write strobe, one-cycle pulse per accepted write.
REQ-015 wr_count  out  CNT_W  count of committed (regwrite=1) writes.

Function
- REQ-016 Transfer occurs when valid and ready are both 1 on a clock edge; ready SHALL NOT depend on the requester's own data.
- REQ-017 At most one of alu_ready and mem_ready SHALL be 1 in any cycle; ready SHALL be 0 whenever the matching valid is 0.
- REQ-018 Only one requester valid: that requester is granted immediately (ready=1 in the same cycle).
- REQ-019 Both valid: winner chosen by a 1-bit priority pointer (state PRI_ALU or PRI_MEM); loser's ready=0 and it SHALL hold valid/rd/data stable.
- REQ-020 After each transfer the pointer SHALL move to favour the non-granted requester; with no transfer the pointer SHALL hold.
- REQ-021 Latency: accepted request appears on rd/writedata with regwrite=1 exactly one cycle after the accepting edge.
- REQ-022 Accepted request with rd index 0 SHALL be acknowledged (ready=1), SHALL produce regwrite=0 the next cycle, and SHALL NOT increment wr_count.
- REQ-023 No transfer in a cycle: next-cycle regwrite=0; rd and writedata SHALL hold their previous values.
- REQ-024 wr_count increments by 1 on each cycle regwrite=1 and SHALL saturate at 2^CNT_W-1 (no wrap).
- REQ-025 Both requesters targeting the same nonzero rd in the same cycle: only the winner is written that cycle; the loser is written in a later cycle, so the loser's value is final (program order is the requesters' responsibility).
- REQ-026 Sustained both-valid traffic SHALL alternate grants every cycle (neither requester waits more than one cycle).

Reset
- REQ-027 While rst=1 on a clock edge: regwrite=0, rd=0, writedata=0, wr_count=0, pointer=PRI_ALU.
- REQ-028 While rst=1, alu_ready and mem_ready SHALL be 0 and no request is accepted.
- REQ-029 rst asserted while a write is on the outputs: that write is dropped (regwrite=0 from the reset edge), and the count is cleared.

Configuration
- REQ-030 Macro WB_ROUND_ROBIN_EN: defined -> arbitration per REQ-019/020; undefined -> fixed priority, mem always wins on contention, pointer logic absent, REQ-026 waived (ALU may starve).

Verification
- REQ-031 Reset then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rd=5, writedata=0xDEADBEEF, regwrite=1, wr_count=1.
- REQ-032 Both valid for 4 cycles after reset (alu_rd=1, mem_rd=2) -> grants ALU, MEM, ALU, MEM; rd sequence 1,2,1,2 one cycle delayed; with WB_ROUND_ROBIN_EN undefined -> MEM granted all 4 cycles.
- REQ-033 mem_valid=1, mem_rd=0, mem_data=0x1234 -> mem_ready=1; next cycle regwrite=0; wr_count unchanged.
- REQ-034 Both valid, same rd=7, alu_data=0xA, mem_data=0xB -> writes 0xA then 0xB on consecutive cycles; loser holds inputs while ready=0.
- REQ-035 CNT_W=4, 20 consecutive nonzero writes -> wr_count reaches 15 and stays 15.
- REQ-036 rst pulsed on the cycle regwrite=1 -> following cycle regwrite=0, wr_count=0, pointer=PRI_ALU (next contention grants ALU).

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ALU and load writeback request handshakes (valid/rd/data in, ready out)
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU/load writebacks onto a registered regfile write port with a saturating write counter; WB_ROUND_ROBIN_EN enables round-robin, else mem wins contention
module regfile_wb_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wb_arbiter_if.slave bus,
  output logic [4:0]          rd,
  output logic [31:0]         writedata,
  output logic                regwrite,
  output logic [CNT_W-1:0]    wr_count
);
  logic        alu_win;
  logic        xfer;
  logic        wr_en;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
`ifdef WB_ROUND_ROBIN_EN
  localparam logic [0:0] PRI_ALU = 1'b0;
  localparam logic [0:0] PRI_MEM = 1'b1;
  logic [0:0] pri;
  assign alu_win = !bus.mem_valid || pri == PRI_ALU;
  always_ff @(posedge clk)
    if (rst) pri <= PRI_ALU;
    else if (xfer) pri <= bus.alu_ready ? PRI_MEM : PRI_ALU;
`else
  assign alu_win = !bus.mem_valid;
`endif
  assign bus.alu_ready = !rst && bus.alu_valid && alu_win;
  assign bus.mem_ready = !rst && bus.mem_valid && !(bus.alu_valid && alu_win);
  assign xfer          = bus.alu_ready || bus.mem_ready;
  assign sel_rd        = bus.alu_ready ? bus.alu_rd : bus.mem_rd;
  assign sel_data      = bus.alu_ready ? bus.alu_data : bus.mem_data;
  assign wr_en         = xfer && sel_rd != 5'd0;
  always_ff @(posedge clk)
    if (rst) begin
      rd        <= '0;
      writedata <= '0;
      regwrite  <= 1'b0;
      wr_count  <= '0;
    end else begin
      regwrite <= wr_en;
      if (xfer) begin
        rd        <= sel_rd;
        writedata <= sel_data;
      end
      if (wr_en && wr_count != '1) wr_count <= wr_count + CNT_W'(1);
    end
endmodule
